f_mult_iter: RTL and testbench

//   Responder side of the FP unit handshake (up_valid/res/down_valid/busy/error) used by FP datapaths.

---
 rtl/float_pkg.sv | 33 +++
 rtl/f_mult_iter_if.sv | 23 ++
 rtl/mant_mul_iter.sv | 68 ++++++
 rtl/f_mult_iter.sv | 218 +++++++++++++++++++++
 tb/tb_f_mult_iter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/float_pkg.sv
// Shared binary64 field widths, constants and FSM encoding for the iterative FP multiplier.
package float_pkg;

    localparam int unsigned FLEN    = 64;
    localparam int unsigned EXP_W   = 11;
    localparam int unsigned FRAC_W  = 52;
    localparam int unsigned MANT_W  = 53;
    localparam int unsigned PROD_W  = 2 * MANT_W;
    localparam int unsigned SEXP_W  = 13;
    localparam int unsigned BIAS    = 1023;
    localparam int unsigned EXP_MAX = 2047;

    localparam logic [FLEN-1:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } f64_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2,
        PACK = 2'd3
    } state_t;

    // Number of shift-add iterations needed to retire all mantissa bits.
    function automatic int unsigned mul_iters(input int unsigned radix_bits);
        return (MANT_W + radix_bits - 1) / radix_bits;
    endfunction

endpackage

// File: rtl/f_mult_iter_if.sv
// FP unit handshake bundle: requester drives operands/strobe, responder returns result/status.
interface f_mult_iter_if;
    import float_pkg::*;

    logic [FLEN-1:0] a;
    logic [FLEN-1:0] b;
    logic            up_valid;
    logic [FLEN-1:0] res;
    logic            down_valid;
    logic            busy;
    logic            error;

    modport master (
        output a, b, up_valid,
        input  res, down_valid, busy, error
    );

    modport slave (
        input  a, b, up_valid,
        output res, down_valid, busy, error
    );

endinterface

// File: rtl/mant_mul_iter.sv
// Iterative 53x53 -> 106 shift-add mantissa multiplier, RADIX_BITS multiplier bits per cycle, LSB first.
module mant_mul_iter
    import float_pkg::*;
#(
    parameter int unsigned RADIX_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W-1:0] ma,
    input  logic [MANT_W-1:0] mb,
    output logic              done_c,
    output logic [PROD_W-1:0] prod
);

    localparam int unsigned N_ITER = mul_iters(RADIX_BITS);
    localparam int unsigned PAD_W  = N_ITER * RADIX_BITS;
    localparam int unsigned CNT_W  = $clog2(N_ITER + 1);

    logic [PROD_W-1:0] acc_q,    acc_d;
    logic [PROD_W-1:0] mcand_q,  mcand_d;
    logic [PAD_W-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [PROD_W-1:0] partial;

    // Each step adds the multiplicand weighted by the low RADIX_BITS multiplier digit.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        partial  = '0;
        if (start) begin
            acc_d    = '0;
            mcand_d  = PROD_W'(ma);
            mplier_d = PAD_W'(mb);
            cnt_d    = CNT_W'(N_ITER);
        end else if (cnt_q != '0) begin
            for (int unsigned j = 0; j < RADIX_BITS; j++) begin
                if (mplier_q[j]) begin
                    partial = partial + (mcand_q << j);
                end
            end
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << RADIX_BITS;
            mplier_d = mplier_q >> RADIX_BITS;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done_c = (cnt_q == CNT_W'(1));
    assign prod   = acc_q;

endmodule

// File: rtl/f_mult_iter.sv
// Iterative binary64 multiplier (RNE, flush-to-zero) behind the FP unit handshake.
// Optional F_MULT_ITER_PROTOCOL_CHECK_EN poisons the next result when a request arrives while busy.
module f_mult_iter
    import float_pkg::*;
#(
    parameter int unsigned RADIX_BITS = 4
) (
    input logic          clk,
    input logic          rst,
    f_mult_iter_if.slave bus
);

    typedef logic signed [SEXP_W-1:0] sexp_t;

    state_t            state_q, state_d;
    logic [FLEN-1:0]   res_q, res_d;
    logic              down_valid_q, down_valid_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;

    logic              sign_q, sign_d;
    logic              nan_q, nan_d;
    logic              zero_q, zero_d;
    sexp_t             exp_q, exp_d;
    logic [MANT_W-1:0] norm_mant_q, norm_mant_d;
    logic              guard_q, guard_d;
    logic              sticky_q, sticky_d;
    sexp_t             norm_exp_q, norm_exp_d;

    f64_t              op_a, op_b;
    logic              accept_c;
    logic              core_done_c;
    logic [PROD_W-1:0] prod;
    logic              viol_rpt_c;

    sexp_t             exp_sum_c;
    logic [MANT_W-1:0] nm_mant_c;
    logic              nm_guard_c;
    logic              nm_sticky_c;
    sexp_t             nm_exp_c;
    logic              rnd_inc_c;
    logic [MANT_W:0]   mant_rnd_c;
    logic [FRAC_W-1:0] frac_fin_c;
    sexp_t             exp_fin_c;
    f64_t              res_pk_c;

    assign op_a = bus.a;
    assign op_b = bus.b;

    mant_mul_iter #(
        .RADIX_BITS (RADIX_BITS)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (accept_c),
        .ma     ({1'b1, op_a.frac}),
        .mb     ({1'b1, op_b.frac}),
        .done_c (core_done_c),
        .prod   (prod)
    );

    // Unpack, normalise and round datapath; the FSM picks which stage result is captured.
    always_comb begin
        exp_sum_c = sexp_t'(SEXP_W'(op_a.exp)) + sexp_t'(SEXP_W'(op_b.exp)) - sexp_t'(SEXP_W'(BIAS));

        if (prod[PROD_W-1]) begin
            nm_mant_c   = prod[PROD_W-1:MANT_W];
            nm_guard_c  = prod[MANT_W-1];
            nm_sticky_c = |prod[MANT_W-2:0];
            nm_exp_c    = exp_q + sexp_t'(1);
        end else begin
            nm_mant_c   = prod[PROD_W-2:MANT_W-1];
            nm_guard_c  = prod[MANT_W-2];
            nm_sticky_c = |prod[MANT_W-3:0];
            nm_exp_c    = exp_q;
        end

        rnd_inc_c  = guard_q & (sticky_q | norm_mant_q[0]);
        mant_rnd_c = {1'b0, norm_mant_q} + (MANT_W+1)'(rnd_inc_c);
        if (mant_rnd_c[MANT_W]) begin
            frac_fin_c = mant_rnd_c[FRAC_W:1];
            exp_fin_c  = norm_exp_q + sexp_t'(1);
        end else begin
            frac_fin_c = mant_rnd_c[FRAC_W-1:0];
            exp_fin_c  = norm_exp_q;
        end

        res_pk_c.sign = sign_q;
        res_pk_c.exp  = exp_fin_c[EXP_W-1:0];
        res_pk_c.frac = frac_fin_c;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        error_d      = error_q;
        down_valid_d = 1'b0;
        accept_c     = 1'b0;
        sign_d       = sign_q;
        nan_d        = nan_q;
        zero_d       = zero_q;
        exp_d        = exp_q;
        norm_mant_d  = norm_mant_q;
        guard_d      = guard_q;
        sticky_d     = sticky_q;
        norm_exp_d   = norm_exp_q;

        unique case (state_q)
            IDLE: begin
                if (bus.up_valid) begin
                    accept_c = 1'b1;
                    sign_d   = op_a.sign ^ op_b.sign;
                    nan_d    = (op_a.exp == EXP_W'(EXP_MAX)) || (op_b.exp == EXP_W'(EXP_MAX));
                    zero_d   = (op_a.exp == '0) || (op_b.exp == '0);
                    exp_d    = exp_sum_c;
                    state_d  = MULT;
                end
            end
            MULT: begin
                if (core_done_c) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                norm_mant_d = nm_mant_c;
                guard_d     = nm_guard_c;
                sticky_d    = nm_sticky_c;
                norm_exp_d  = nm_exp_c;
                state_d     = PACK;
            end
            PACK: begin
                down_valid_d = 1'b1;
                state_d      = IDLE;
                // Specials first, then zero operands, so garbage products never leak out.
                if (viol_rpt_c || nan_q) begin
                    res_d   = QNAN;
                    error_d = 1'b1;
                end else if (zero_q) begin
                    res_d   = {sign_q, (FLEN-1)'(0)};
                    error_d = 1'b0;
                end else if (exp_fin_c >= sexp_t'(SEXP_W'(EXP_MAX))) begin
                    res_d   = QNAN;
                    error_d = 1'b1;
                end else if (exp_fin_c <= sexp_t'(0)) begin
                    res_d   = {sign_q, (FLEN-1)'(0)};
                    error_d = 1'b0;
                end else begin
                    res_d   = res_pk_c;
                    error_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            res_q        <= '0;
            down_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            sign_q       <= 1'b0;
            nan_q        <= 1'b0;
            zero_q       <= 1'b0;
            exp_q        <= '0;
            norm_mant_q  <= '0;
            guard_q      <= 1'b0;
            sticky_q     <= 1'b0;
            norm_exp_q   <= '0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            down_valid_q <= down_valid_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            sign_q       <= sign_d;
            nan_q        <= nan_d;
            zero_q       <= zero_d;
            exp_q        <= exp_d;
            norm_mant_q  <= norm_mant_d;
            guard_q      <= guard_d;
            sticky_q     <= sticky_d;
            norm_exp_q   <= norm_exp_d;
        end
    end

`ifdef F_MULT_ITER_PROTOCOL_CHECK_EN
    logic viol_q, viol_d;
    logic viol_set_c;

    // A request during the PACK cycle still belongs to the op being reported.
    always_comb begin
        viol_set_c = bus.up_valid & busy_q;
        viol_rpt_c = viol_q | viol_set_c;
        viol_d     = down_valid_d ? 1'b0 : viol_rpt_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            viol_q <= 1'b0;
        end else begin
            viol_q <= viol_d;
        end
    end
`else
    assign viol_rpt_c = 1'b0;
`endif

    assign bus.res        = res_q;
    assign bus.down_valid = down_valid_q;
    assign bus.busy       = busy_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_f_mult_iter.sv
// Scoreboard bench for f_mult_iter: directed IEEE cases, handshake corners, async reset, random ops.
module tb_f_mult_iter #(
    parameter int unsigned RADIX_BITS = 4
);

    localparam int unsigned N_IT = (53 + RADIX_BITS - 1) / RADIX_BITS;
    localparam int unsigned LAT  = N_IT + 2;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    f_mult_iter_if bus();

    f_mult_iter #(.RADIX_BITS(RADIX_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int unsigned edge_n     = 0;
    int unsigned busy_until = 0;
    int unsigned n_acc      = 0;
    logic [63:0] last_res   = '0;
    logic        last_err   = 1'b0;
    int          n_chk      = 0;
    int          n_fail     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    // Reference product from the arithmetic definition: exact product, then RNE by remainder.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic e);
        logic [10:0]  ea, eb;
        logic         s;
        logic [127:0] p, q, rem, half;
        int           sh, ex;
        ea = a[62:52];
        eb = b[62:52];
        s  = a[63] ^ b[63];
        r  = '0;
        e  = 1'b0;
        if (ea == 11'h7FF || eb == 11'h7FF) begin
            r = QNAN;
            e = 1'b1;
        end else if (ea == 11'h000 || eb == 11'h000) begin
            r = {s, 63'd0};
        end else begin
            p    = {75'd0, 1'b1, a[51:0]} * {75'd0, 1'b1, b[51:0]};
            sh   = p[105] ? 53 : 52;
            ex   = int'(ea) + int'(eb) - 1023 + (p[105] ? 1 : 0);
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 128'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 128'd1;
            if (q == (128'd1 << 53)) begin
                q  = q >> 1;
                ex = ex + 1;
            end
            if (ex >= 2047) begin
                r = QNAN;
                e = 1'b1;
            end else if (ex <= 0) begin
                r = {s, 63'd0};
            end else begin
                r = {s, ex[10:0], q[51:0]};
            end
        end
    endfunction

    function automatic logic [63:0] rand_op();
        logic [63:0] raw;
        logic [10:0] ex;
        logic [51:0] fr;
        int unsigned sel;
        raw = {$urandom, $urandom};
        fr  = raw[51:0];
        sel = $urandom_range(0, 15);
        case (sel)
            0:       ex = 11'h000;
            1:       ex = 11'h7FF;
            2, 3:    ex = 11'($urandom_range(1, 2046));
            default: ex = 11'($urandom_range(423, 1623));
        endcase
        sel = $urandom_range(0, 7);
        if (sel == 0) fr = '0;
        else if (sel == 1) fr = '1;
        return {1'($urandom_range(0, 1)), ex, fr};
    endfunction

    // One clock of stimulus; acceptance is decided by the bench's own busy model.
    task automatic cycle(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic use_k, input logic [63:0] kr, input logic ke);
        exp_t ent;
        bus.up_valid = v;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        edge_n++;
        if (v && rst) begin
            if (edge_n > busy_until) begin
                if (use_k) begin
                    ent.res = kr;
                    ent.err = ke;
                end else begin
                    model(a, b, ent.res, ent.err);
                end
                ent.due    = edge_n + LAT;
                busy_until = edge_n + LAT;
                n_acc++;
                sb_q.push_back(ent);
            end else begin
`ifdef F_MULT_ITER_PROTOCOL_CHECK_EN
                if (sb_q.size() != 0) begin
                    ent         = sb_q[sb_q.size()-1];
                    ent.res     = QNAN;
                    ent.err     = 1'b1;
                    sb_q[sb_q.size()-1] = ent;
                end
`endif
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        cycle(1'b1, a, b, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic issue_k(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] r, input logic e);
        cycle(1'b1, a, b, 1'b1, r, e);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 4 * LAT) begin
            idle(1);
            g++;
        end
        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        idle(2);
    endtask

    // Monitor: pops on every strobe, otherwise checks hold values and overdue results.
    always @(negedge clk) begin
        exp_t ent;
        if (bus.down_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", 64'(bus.down_valid), 64'd0);
            end else begin
                ent = sb_q.pop_front();
                chk("res", bus.res, ent.res);
                chk("error", 64'(bus.error), 64'(ent.err));
                chk("latency_edge", 64'(edge_n), 64'(ent.due));
                last_res = ent.res;
                last_err = ent.err;
            end
        end else begin
            if (sb_q.size() != 0 && sb_q[0].due <= edge_n) begin
                chk("missing_strobe", 64'(bus.down_valid), 64'd1);
                void'(sb_q.pop_front());
            end
            chk("res_hold", bus.res, last_res);
            chk("error_hold", 64'(bus.error), 64'(last_err));
        end
        chk("busy", 64'(bus.busy), 64'(edge_n < busy_until));
    end

    initial begin
        #1_000_000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, edge %0d", edge_n);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int unsigned acc0;
        logic        v;
        rst          = 1'b0;
        bus.up_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        #12;
        chk("rst_res", bus.res, 64'd0);
        chk("rst_down_valid", 64'(bus.down_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        rst = 1'b1;
        idle(2);

        issue_k(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h4018_0000_0000_0000, 1'b0);
        wait_drain();
        issue_k(64'h4010_0000_0000_0000, 64'hBFE0_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b0);
        wait_drain();
        issue_k(64'h0000_0000_0000_0000, 64'hC014_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        wait_drain();
        issue_k(64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0002, 1'b0);
        wait_drain();
        issue_k(64'h7FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, QNAN, 1'b1);
        wait_drain();
        issue_k(64'h7FE1_CCF3_85EB_C8A0, 64'h7FE1_CCF3_85EB_C8A0, QNAN, 1'b1);
        wait_drain();
        issue_k(64'h1668_7E92_154E_F7AC, 64'h1668_7E92_154E_F7AC, 64'h0000_0000_0000_0000, 1'b0);
        wait_drain();

        // Back-to-back: second request lands in the down_valid cycle of the first.
        issue(64'h3FF8_0000_0000_0000, 64'hC00C_0000_0000_0000);
        idle(LAT);
        issue_k(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h4018_0000_0000_0000, 1'b0);
        wait_drain();

        // Request mid-operation is dropped (poisons the result when checking is built in).
        issue_k(64'h4010_0000_0000_0000, 64'hBFE0_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b0);
        idle(3);
        issue(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000);
        wait_drain();
        issue_k(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h4018_0000_0000_0000, 1'b0);
        wait_drain();

        // Asynchronous reset during MULT discards the operation.
        issue(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000);
        idle(3);
        rst = 1'b0;
        #1;
        chk("arst_res", bus.res, 64'd0);
        chk("arst_down_valid", 64'(bus.down_valid), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_error", 64'(bus.error), 64'd0);
        sb_q.delete();
        busy_until = edge_n;
        last_res   = '0;
        last_err   = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(LAT + 4);
        issue_k(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h4018_0000_0000_0000, 1'b0);
        wait_drain();

        // Random traffic, mostly when idle, occasionally while busy.
        acc0 = n_acc;
        for (int i = 0; i < 4000 && (n_acc - acc0) < 30; i++) begin
            if (edge_n + 1 <= busy_until) v = ($urandom_range(0, 15) == 0);
            else                          v = ($urandom_range(0, 3) != 0);
            cycle(v, rand_op(), rand_op(), 1'b0, 64'd0, 1'b0);
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
